// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_bridge_pkg                                                  |
// | Brief    : Shared encodings and helpers for the AHB-lite to APB4 bridge:   |
// |            FSM state codes, HTRANS/HRESP/HSIZE codes, strobe generation.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package apb_bridge_pkg;

    // Bridge FSM state encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_access = 3'd2;
    localparam logic [2:0] c_st_err1   = 3'd3;
    localparam logic [2:0] c_st_err2   = 3'd4;

    // AHB transfer types
    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    // AHB responses
    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;

    // AHB transfer sizes the bridge supports
    localparam logic [2:0] c_hsize_byte = 3'b000;
    localparam logic [2:0] c_hsize_half = 3'b001;
    localparam logic [2:0] c_hsize_word = 3'b010;

    // Byte-lane strobes for a write of the given size at the given low address bits
    function automatic logic [3:0] apb_strb(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            c_hsize_byte: strb = 4'b0001 << addr_lo;
            c_hsize_half: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            c_hsize_word: strb = 4'b1111;
            default:      strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_bridge_rdmux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_bridge_rdmux                                                |
// | Brief    : Selects the addressed slave's prdata/pready/pslverr using the   |
// |            slave index latched in the address phase.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module apb_bridge_rdmux #(
    parameter int NUM_SLV = 4,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [NUM_SLV*32-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]    i_pready,
    input  logic [NUM_SLV-1:0]    i_pslverr,
    output logic [31:0]           o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);

    // An index with no slave behind it reads back as not-ready, no data
    always_comb begin
        o_prdata  = '0;
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_prdata  = i_prdata[32*i +: 32];
                o_pready  = i_pready[i];
                o_pslverr = i_pslverr[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_bridge_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_bridge_ctrl                                                 |
// | Brief    : AHB-lite responder bridging single transfers onto an APB4 bus   |
// |            with NUM_SLV one-hot selected peripherals. Decode faults and    |
// |            pslverr become a two-cycle AHB ERROR response.                  |
// | Options  : APB_TIMEOUT_EN - abort ACCESS after TIMEOUT_CYC stalled cycles. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module apb_bridge_ctrl #(
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  pll_core_cpuclk,
    input  logic                  pad_cpu_rst_b,
    input  logic                  apb_hsel,
    input  logic [39:0]           apb_haddr,
    input  logic [2:0]            apb_hburst,
    input  logic [2:0]            apb_hsize,
    input  logic [1:0]            apb_htrans,
    input  logic                  apb_hwrite,
    input  logic [31:0]           apb_hwdata,
    output logic [31:0]           apb_hrdata,
    output logic                  apb_hready,
    output logic [1:0]            apb_hresp,
    output logic [31:0]           paddr,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [NUM_SLV*32-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    input  logic [NUM_SLV-1:0]    pslverr
);

    import apb_bridge_pkg::*;

    localparam int c_idx_w = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [31:0]        r_addr;
    logic               r_write;
    logic [2:0]         r_size;
    logic [c_idx_w-1:0] r_idx;
    logic [31:0]        r_pwdata;

    logic               w_req;
    logic               w_accept;
    logic               w_dec_err;
    logic               w_hready;
    logic [1:0]         w_hresp;
    logic [31:0]        w_hrdata;
    logic               w_timeout;
    logic [31:0]        w_sel_prdata;
    logic               w_sel_pready;
    logic               w_sel_pslverr;
    logic               w_unused;

    // Burst type is irrelevant: every beat is handled as a single transfer
    assign w_unused = ^{apb_hburst, TIMEOUT_CYC};

    apb_bridge_rdmux #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (c_idx_w)
    ) u_rdmux (
        .i_idx     (r_idx),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr),
        .o_prdata  (w_sel_prdata),
        .o_pready  (w_sel_pready),
        .o_pslverr (w_sel_pslverr)
    );

    // Only NONSEQ/SEQ on a selected bus are real transfer requests
    always_comb begin
        w_req = 1'b0;
        case (apb_htrans)
            c_htrans_nonseq, c_htrans_seq: w_req = apb_hsel;
            c_htrans_idle,   c_htrans_busy: w_req = 1'b0;
            default:                        w_req = 1'b0;
        endcase
    end

    // Out-of-window address, oversized or misaligned transfers never reach APB
    assign w_dec_err = (apb_haddr[39:32] != 8'h00)
                    || (apb_hsize > c_hsize_word)
                    || ((apb_hsize == c_hsize_half) && apb_haddr[0])
                    || ((apb_hsize == c_hsize_word) && (apb_haddr[1:0] != 2'b00));

    // Requests are only sampled while hready is high
    assign w_accept = w_req & w_hready;

`ifdef APB_TIMEOUT_EN
    localparam int              c_tmo_w    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    // Count stalled ACCESS cycles; restart every time a new APB cycle is set up
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_st_setup) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_st_access) && !w_sel_pready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == c_st_access) && !w_sel_pready && (r_tmo_cnt == c_tmo_last);
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and AHB response decode
    always_comb begin
        w_state_nxt = r_state;
        w_hready    = 1'b1;
        w_hresp     = c_hresp_okay;
        w_hrdata    = '0;
        case (r_state)
            c_st_idle: begin
                if (w_req) w_state_nxt = w_dec_err ? c_st_err1 : c_st_setup;
            end
            c_st_setup: begin
                w_hready    = 1'b0;
                w_state_nxt = c_st_access;
            end
            c_st_access: begin
                if (w_timeout) begin
                    w_hready    = 1'b0;
                    w_state_nxt = c_st_err1;
                end else if (!w_sel_pready) begin
                    w_hready    = 1'b0;
                end else if (w_sel_pslverr) begin
                    w_hready    = 1'b0;
                    w_state_nxt = c_st_err1;
                end else begin
                    w_hrdata = r_write ? 32'h0 : w_sel_prdata;
                    if (w_req) w_state_nxt = w_dec_err ? c_st_err1 : c_st_setup;
                    else       w_state_nxt = c_st_idle;
                end
            end
            c_st_err1: begin
                w_hready    = 1'b0;
                w_hresp     = c_hresp_error;
                w_state_nxt = c_st_err2;
            end
            c_st_err2: begin
                w_hresp = c_hresp_error;
                if (w_req) w_state_nxt = w_dec_err ? c_st_err1 : c_st_setup;
                else       w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Address-phase capture; held stable until the next accepted transfer
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_addr  <= apb_haddr[31:0];
            r_write <= apb_hwrite;
            r_size  <= apb_hsize;
            r_idx   <= apb_haddr[SLV_SEL_LSB +: c_idx_w];
        end
    end

    // Write data arrives in the SETUP cycle; hold it for the ACCESS phase
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_pwdata <= '0;
        end else if (r_state == c_st_setup) begin
            r_pwdata <= apb_hwdata;
        end
    end

    assign apb_hready = w_hready;
    assign apb_hresp  = w_hresp;
    assign apb_hrdata = w_hrdata;

    assign psel    = ((r_state == c_st_setup) || (r_state == c_st_access))
                   ? (NUM_SLV'(1) << r_idx) : '0;
    assign penable = (r_state == c_st_access);
    assign paddr   = r_addr;
    assign pwrite  = r_write;
    assign pwdata  = (r_state == c_st_setup) ? apb_hwdata : r_pwdata;
    assign pstrb   = r_write ? apb_strb(r_size, r_addr[1:0]) : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_bridge_ctrl                                              |
// | Brief    : Self-checking bench for apb_bridge_ctrl. A transaction-level    |
// |            model sets per-cycle expectations; a negedge process compares.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_apb_bridge_ctrl;

    localparam int NUM_SLV = 4;

    logic                  pll_core_cpuclk = 1'b0;
    logic                  pad_cpu_rst_b;
    logic                  apb_hsel;
    logic [39:0]           apb_haddr;
    logic [2:0]            apb_hburst;
    logic [2:0]            apb_hsize;
    logic [1:0]            apb_htrans;
    logic                  apb_hwrite;
    logic [31:0]           apb_hwdata;
    logic [31:0]           apb_hrdata;
    logic                  apb_hready;
    logic [1:0]            apb_hresp;
    logic [31:0]           paddr;
    logic [NUM_SLV-1:0]    psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [NUM_SLV*32-1:0] prdata;
    logic [NUM_SLV-1:0]    pready;
    logic [NUM_SLV-1:0]    pslverr;

    apb_bridge_ctrl #(
        .NUM_SLV     (NUM_SLV),
        .SLV_SEL_LSB (12),
        .TIMEOUT_CYC (8)
    ) dut (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .apb_hsel        (apb_hsel),
        .apb_haddr       (apb_haddr),
        .apb_hburst      (apb_hburst),
        .apb_hsize       (apb_hsize),
        .apb_htrans      (apb_htrans),
        .apb_hwrite      (apb_hwrite),
        .apb_hwdata      (apb_hwdata),
        .apb_hrdata      (apb_hrdata),
        .apb_hready      (apb_hready),
        .apb_hresp       (apb_hresp),
        .paddr           (paddr),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr)
    );

    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    typedef struct {
        logic [39:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        bit          slverr;
        logic [31:0] rdata;
    } xfer_t;

    int checks   = 0;
    int failures = 0;

    // Per-cycle expectations produced by the transaction model
    bit                 e_on = 1'b0;
    logic               e_hready;
    logic [1:0]         e_hresp;
    logic [NUM_SLV-1:0] e_psel;
    logic               e_penable;
    bit                 e_apb, e_wd, e_rd;
    logic [31:0]        e_paddr, e_pwdata, e_hrdata;
    logic               e_pwrite;
    logic [3:0]         e_pstrb;

    // Observations used for the literal pins
    logic [NUM_SLV-1:0] s_psel;
    logic [3:0]         s_pstrb;
    logic [31:0]        s_paddr, s_pwdata, s_hrdata;
    int                 n_wait, n_err, n_psel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model rules
    function automatic bit model_dec_err(input logic [39:0] a, input logic [2:0] sz);
        if (a[39:32] != 8'h00) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if ((sz == 3'd1) && a[0]) return 1'b1;
        if ((sz == 3'd2) && (a[1:0] != 2'b00)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(input bit wr, input logic [2:0] sz, input logic [31:0] a);
        int nbytes;
        int lanes;
        if (!wr) return 4'b0000;
        nbytes = 1 << sz;
        lanes  = ((1 << nbytes) - 1) << a[1:0];
        return lanes[3:0];
    endfunction

    function automatic xfer_t mk(input logic [39:0] a, input bit wr, input logic [2:0] sz,
                                 input logic [31:0] wd, input int w, input bit se, input logic [31:0] rd);
        xfer_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.wdata = wd; t.waits = w; t.slverr = se; t.rdata = rd;
        return t;
    endfunction

    // Compare every meaningful cycle and collect observations
    always @(negedge pll_core_cpuclk) begin
        if (e_on) begin
            chk("hready", 64'(apb_hready), 64'(e_hready));
            chk("hresp", 64'(apb_hresp), 64'(e_hresp));
            chk("psel", 64'(psel), 64'(e_psel));
            chk("penable", 64'(penable), 64'(e_penable));
            if (e_apb) begin
                chk("paddr", 64'(paddr), 64'(e_paddr));
                chk("pwrite", 64'(pwrite), 64'(e_pwrite));
                chk("pstrb", 64'(pstrb), 64'(e_pstrb));
            end
            if (e_wd) chk("pwdata", 64'(pwdata), 64'(e_pwdata));
            if (e_rd) chk("hrdata", 64'(apb_hrdata), 64'(e_hrdata));
            if (!apb_hready) n_wait++;
            if (apb_hresp == 2'b01) n_err++;
        end
        if (psel != '0) n_psel++;
        if ((psel != '0) && !penable) begin
            s_psel = psel; s_pstrb = pstrb; s_paddr = paddr; s_pwdata = pwdata;
        end
        if (apb_hready && penable) s_hrdata = apb_hrdata;
    end

    task automatic cyc();
        @(posedge pll_core_cpuclk);
        #1;
    endtask

    task automatic set_bus(input logic hr, input logic [1:0] hresp, input logic [NUM_SLV-1:0] ps, input logic pen);
        e_hready = hr; e_hresp = hresp; e_psel = ps; e_penable = pen;
        e_apb = 1'b0; e_wd = 1'b0; e_rd = 1'b0;
    endtask

    task automatic set_apb(input xfer_t t);
        e_apb    = 1'b1;
        e_paddr  = t.addr[31:0];
        e_pwrite = t.wr;
        e_pstrb  = model_strb(t.wr, t.size, t.addr[31:0]);
        e_wd     = t.wr;
        e_pwdata = t.wdata;
    endtask

    task automatic drive_addr(input xfer_t t);
        apb_hsel = 1'b1; apb_htrans = 2'b10; apb_hburst = 3'b001;
        apb_haddr = t.addr; apb_hwrite = t.wr; apb_hsize = t.size;
    endtask

    task automatic drive_idle();
        apb_hsel = 1'b1; apb_htrans = 2'b00;
    endtask

    // Addressed slave gets the given response; every other slave looks ready and erroring
    task automatic slaves(input int idx, input bit rdy, input bit err, input logic [31:0] data);
        for (int i = 0; i < NUM_SLV; i++) begin
            if (i == idx) begin
                pready[i] = rdy; pslverr[i] = err; prdata[32*i +: 32] = data;
            end else begin
                pready[i] = 1'b1; pslverr[i] = 1'b1; prdata[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
            end
        end
    endtask

    task automatic idle(input int k);
        drive_idle();
        set_bus(1'b1, 2'b00, '0, 1'b0);
        repeat (k) cyc();
    endtask

    // Address phase of a transfer presented to an idle bridge
    task automatic start(input xfer_t t);
        drive_addr(t);
        set_bus(1'b1, 2'b00, '0, 1'b0);
        cyc();
    endtask

    // Data phase of t; optionally hold the next transfer's address phase throughout
    task automatic run_data(input xfer_t t, input bit nv, input xfer_t n);
        int                 idx;
        logic [NUM_SLV-1:0] oh;
        idx = int'(t.addr[13:12]);
        oh  = NUM_SLV'(1) << idx;
        if (nv) drive_addr(n); else drive_idle();
        apb_hwdata = t.wdata;
        if (model_dec_err(t.addr, t.size)) begin
            set_bus(1'b0, 2'b01, '0, 1'b0); cyc();
            set_bus(1'b1, 2'b01, '0, 1'b0); cyc();
        end else begin
            slaves(idx, 1'b0, 1'b0, ~t.rdata);
            set_bus(1'b0, 2'b00, oh, 1'b0); set_apb(t); cyc();
            repeat (t.waits) begin
                set_bus(1'b0, 2'b00, oh, 1'b1); set_apb(t); cyc();
            end
            slaves(idx, 1'b1, t.slverr, t.rdata);
            if (t.slverr) begin
                set_bus(1'b0, 2'b00, oh, 1'b1); set_apb(t); cyc();
                set_bus(1'b0, 2'b01, '0, 1'b0); cyc();
                set_bus(1'b1, 2'b01, '0, 1'b0); cyc();
            end else begin
                set_bus(1'b1, 2'b00, oh, 1'b1); set_apb(t);
                e_rd = 1'b1; e_hrdata = t.wr ? 32'h0 : t.rdata;
                cyc();
            end
        end
    endtask

    task automatic single(input xfer_t t);
        xfer_t none;
        none = mk(40'h0, 1'b0, 3'd0, 32'h0, 0, 1'b0, 32'h0);
        start(t);
        run_data(t, 1'b0, none);
        idle(1);
    endtask

    task automatic chk_reset_values();
        chk("rst_hready", 64'(apb_hready), 64'd1);
        chk("rst_hresp", 64'(apb_hresp), 64'd0);
        chk("rst_hrdata", 64'(apb_hrdata), 64'd0);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t t, n;
        pad_cpu_rst_b = 1'b0;
        apb_hsel = 1'b0; apb_haddr = '0; apb_hburst = '0; apb_hsize = '0;
        apb_htrans = 2'b00; apb_hwrite = 1'b0; apb_hwdata = '0;
        prdata = '0; pready = '0; pslverr = '0;
        repeat (2) cyc();
        chk_reset_values();
        pad_cpu_rst_b = 1'b1;
        e_on = 1'b1;

        // Idle / busy / deselected traffic: zero-wait OKAY, no APB activity
        idle(2);
        apb_htrans = 2'b01; cyc();
        apb_hsel = 1'b0; apb_htrans = 2'b10; apb_haddr = 40'h1000; cyc();
        idle(1);

        // Word write to slave 2
        n_wait = 0;
        single(mk(40'h0000_2004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0));
        chk("wr_psel_lit", 64'(s_psel), 64'h4);
        chk("wr_paddr_lit", 64'(s_paddr), 64'h2004);
        chk("wr_pstrb_lit", 64'(s_pstrb), 64'hF);
        chk("wr_pwdata_lit", 64'(s_pwdata), 64'hDEAD_BEEF);
        chk("wr_wait_cycles", 64'(n_wait), 64'd1);

        // Read from slave 1 with three stalled ACCESS cycles
        n_wait = 0;
        single(mk(40'h0000_1000, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678));
        chk("rd_wait_cycles", 64'(n_wait), 64'd4);
        chk("rd_hrdata_lit", 64'(s_hrdata), 64'h1234_5678);

        // Narrow writes and a misaligned halfword
        single(mk(40'h0000_3003, 1'b1, 3'd0, 32'hAA00_0000, 0, 1'b0, 32'h0));
        chk("byte_pstrb_lit", 64'(s_pstrb), 64'h8);
        single(mk(40'h0000_3002, 1'b1, 3'd1, 32'hBBBB_0000, 1, 1'b0, 32'h0));
        chk("half_pstrb_lit", 64'(s_pstrb), 64'hC);
        n_psel = 0; n_err = 0;
        single(mk(40'h0000_3001, 1'b1, 3'd1, 32'h0000_CC00, 0, 1'b0, 32'h0));
        chk("mis_psel_cnt", 64'(n_psel), 64'd0);
        chk("mis_err_cycles", 64'(n_err), 64'd2);

        // pslverr on a read, with a write waiting to be accepted in ERR2
        n_err = 0;
        t = mk(40'h0000_0000, 1'b0, 3'd2, 32'h0, 1, 1'b1, 32'h5A5A_5A5A);
        n = mk(40'h0000_1008, 1'b1, 3'd2, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
        start(t);
        run_data(t, 1'b1, n);
        run_data(n, 1'b0, t);
        idle(1);
        chk("slverr_err_cycles", 64'(n_err), 64'd2);
        chk("after_err_paddr_lit", 64'(s_paddr), 64'h1008);

        // Decode errors: upper address bits and oversized transfer
        n_psel = 0;
        single(mk(40'h01_0000_0000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0));
        single(mk(40'h00_0000_0000, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'h0));
        chk("dec_psel_cnt", 64'(n_psel), 64'd0);

        // Back-to-back writes: slave 0 then slave 3
        t = mk(40'h0000_0010, 1'b1, 3'd2, 32'h1111_1111, 0, 1'b0, 32'h0);
        n = mk(40'h0000_3000, 1'b1, 3'd2, 32'h2222_2222, 1, 1'b0, 32'h0);
        start(t);
        run_data(t, 1'b1, n);
        run_data(n, 1'b0, t);
        idle(1);
        chk("b2b_psel_lit", 64'(s_psel), 64'h8);

`ifdef APB_TIMEOUT_EN
        // Stalled slave: eight ACCESS cycles, then ERR1/ERR2 with a late pready ignored
        t = mk(40'h0000_1000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0);
        start(t);
        drive_idle();
        slaves(1, 1'b0, 1'b0, 32'h0);
        set_bus(1'b0, 2'b00, 4'b0010, 1'b0); cyc();
        repeat (8) begin
            set_bus(1'b0, 2'b00, 4'b0010, 1'b1); cyc();
        end
        slaves(1, 1'b1, 1'b0, 32'h55);
        set_bus(1'b0, 2'b01, '0, 1'b0); cyc();
        set_bus(1'b1, 2'b01, '0, 1'b0); cyc();
        idle(1);
`endif

        // Reset asserted in the middle of an ACCESS wait
        t = mk(40'h0000_1000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0);
        start(t);
        drive_idle();
        slaves(1, 1'b0, 1'b0, 32'h0);
        set_bus(1'b0, 2'b00, 4'b0010, 1'b0); cyc();
        set_bus(1'b0, 2'b00, 4'b0010, 1'b1); cyc();
        #2;
        e_on = 1'b0;
        pad_cpu_rst_b = 1'b0;
        #1;
        chk_reset_values();
        cyc();
        pad_cpu_rst_b = 1'b1;
        e_on = 1'b1;
        idle(2);

        e_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
